// File: rtl/cordic_seq_if.sv
// Control bundle between the CORDIC iteration sequencer and the rest of the
// datapath: start request and unit status in, iteration/enable/ops/status out.
interface cordic_seq_if #(
    parameter int IW = 5
) ();
    logic          go;
    logic          z_sign;
    logic          x_done;
    logic          y_done;
    logic          z_done;
    logic [IW-1:0] iter;
    logic          start;
    logic          op_x;
    logic          op_y;
    logic          op_z;
    logic          busy;
    logic          done;
    logic          err;

    // Sequencer side: drives iteration control, reads unit status.
    modport master (
        input  go, z_sign, x_done, y_done, z_done,
        output iter, start, op_x, op_y, op_z, busy, done, err
    );

    // Datapath / top-level side: the mirror image.
    modport slave (
        output go, z_sign, x_done, y_done, z_done,
        input  iter, start, op_x, op_y, op_z, busy, done, err
    );
endinterface

// File: rtl/cordic_seq.sv
// Rotation-mode iteration sequencer for the bit-serial CORDIC datapath.
// Walks iter 0 (load), 1..N_ITER, raising start for each shift-and-compute
// pass, picks add/subtract direction from the z sign before each pass, waits
// for all three unit dones (with a watchdog) and reports done or err.
module cordic_seq #(
    parameter int N_ITER  = 16,
    parameter int TIMEOUT = 64,
    parameter int IW      = 5
) (
    input  logic         clk,
    input  logic         rst,
    cordic_seq_if.master io_seq
);

    localparam int              WW           = $clog2(TIMEOUT + 1);
    localparam logic [IW-1:0]   LP_ITER_LAST = IW'(N_ITER);
    localparam logic [WW-1:0]   LP_WD_LAST   = WW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ARM,
        S_SHIFT,
        S_DROP,
        S_FINISH,
        S_ERROR
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [IW-1:0] r_iter;
    logic [IW-1:0] w_iter_nxt;
    logic          r_op_x;
    logic          r_op_y;
    logic          r_op_z;
    logic          w_op_x_nxt;
    logic          w_op_y_nxt;
    logic          w_op_z_nxt;
    logic          r_fx;
    logic          r_fy;
    logic          r_fz;
    logic          w_fx_nxt;
    logic          w_fy_nxt;
    logic          w_fz_nxt;
    logic [WW-1:0] r_wd;
    logic [WW-1:0] w_wd_nxt;

    // Sticky flags merged with this cycle's dones, so same-cycle arrivals count.
    logic w_fx_set;
    logic w_fy_set;
    logic w_fz_set;
    logic w_all_done;
    logic w_wd_hit;

    assign w_fx_set   = r_fx | io_seq.x_done;
    assign w_fy_set   = r_fy | io_seq.y_done;
    assign w_fz_set   = r_fz | io_seq.z_done;
    assign w_all_done = w_fx_set & w_fy_set & w_fz_set;
    // True in the SHIFT cycle that brings the watchdog up to TIMEOUT.
    assign w_wd_hit   = (r_wd == LP_WD_LAST);

    // State and datapath-control registers; reset aborts any run at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_iter  <= '0;
            r_op_x  <= 1'b0;
            r_op_y  <= 1'b0;
            r_op_z  <= 1'b0;
            r_fx    <= 1'b0;
            r_fy    <= 1'b0;
            r_fz    <= 1'b0;
            r_wd    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_iter  <= w_iter_nxt;
            r_op_x  <= w_op_x_nxt;
            r_op_y  <= w_op_y_nxt;
            r_op_z  <= w_op_z_nxt;
            r_fx    <= w_fx_nxt;
            r_fy    <= w_fy_nxt;
            r_fz    <= w_fz_nxt;
            r_wd    <= w_wd_nxt;
        end
    end

    // Next-state logic: everything holds unless the current state moves it.
    always_comb begin
        w_state_nxt = r_state;
        w_iter_nxt  = r_iter;
        w_op_x_nxt  = r_op_x;
        w_op_y_nxt  = r_op_y;
        w_op_z_nxt  = r_op_z;
        w_fx_nxt    = r_fx;
        w_fy_nxt    = r_fy;
        w_fz_nxt    = r_fz;
        w_wd_nxt    = r_wd;

        case (r_state)
            // Idle keeps iter where it was so finished results stay frozen;
            // ERROR restarts the same way and leaving it drops err.
            S_IDLE, S_ERROR: begin
                if (io_seq.go) begin
                    w_state_nxt = S_LOAD;
                    w_iter_nxt  = '0;
                end
            end

            // iter=0 for this single cycle makes the units load x0/y0/z0.
            S_LOAD: begin
                w_iter_nxt  = IW'(1);
                w_state_nxt = S_ARM;
            end

            // Direction is frozen here and held for the whole pass. Flags are
            // also cleared here because an ERROR exit can leave some set.
            S_ARM: begin
                w_op_z_nxt  = ~io_seq.z_sign;
                w_op_x_nxt  = ~io_seq.z_sign;
                w_op_y_nxt  =  io_seq.z_sign;
                w_fx_nxt    = 1'b0;
                w_fy_nxt    = 1'b0;
                w_fz_nxt    = 1'b0;
                w_wd_nxt    = '0;
                w_state_nxt = S_SHIFT;
            end

            // Completion is tested before the watchdog so it wins a tie.
            S_SHIFT: begin
                w_fx_nxt = w_fx_set;
                w_fy_nxt = w_fy_set;
                w_fz_nxt = w_fz_set;
                w_wd_nxt = r_wd + WW'(1);
                if (w_all_done) begin
                    w_state_nxt = S_DROP;
                end else if (w_wd_hit) begin
                    w_state_nxt = S_ERROR;
                end
            end

            // start low for a cycle resets the unit counters and done flags.
            S_DROP: begin
                w_fx_nxt = 1'b0;
                w_fy_nxt = 1'b0;
                w_fz_nxt = 1'b0;
                if (r_iter == LP_ITER_LAST) begin
                    w_state_nxt = S_FINISH;
                end else begin
                    w_iter_nxt  = r_iter + IW'(1);
                    w_state_nxt = S_ARM;
                end
            end

            // go is deliberately not looked at here; IDLE picks it up next.
            S_FINISH: begin
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign io_seq.iter  = r_iter;
    assign io_seq.op_x  = r_op_x;
    assign io_seq.op_y  = r_op_y;
    assign io_seq.op_z  = r_op_z;
    assign io_seq.start = (r_state == S_SHIFT);
    assign io_seq.busy  = (r_state == S_LOAD) || (r_state == S_ARM) ||
                          (r_state == S_SHIFT) || (r_state == S_DROP);
    assign io_seq.done  = (r_state == S_FINISH);
    assign io_seq.err   = (r_state == S_ERROR);

endmodule

// File: tb/tb_cordic_seq.sv
// Directed bench for cordic_seq: a small unit model answers start with done
// pulses at programmable delays; expected values are hand-computed.
module tb_cordic_seq;

    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_pass = 0;

    // Unit model controls: 0 = all dones after d_lat cycles, 1 = staggered
    // x@5 z@9 y@12, 2 = y never answers.
    int         mode  = 0;
    int         d_lat = 17;
    logic [7:0] shcnt;

    cordic_seq_if #(.IW(5)) u_if ();

    cordic_seq #(
        .N_ITER (16),
        .TIMEOUT(64),
        .IW     (5)
    ) u_dut (
        .clk   (clk),
        .rst   (rst),
        .io_seq(u_if)
    );

    always #5 clk = ~clk;

    // Count of cycles start has been high in the current pass.
    always_ff @(posedge clk) begin
        if (!u_if.start) shcnt <= '0;
        else             shcnt <= shcnt + 8'd1;
    end

    // Done pulses: shcnt==k-1 is the k-th SHIFT cycle.
    always_comb begin
        u_if.x_done = 1'b0;
        u_if.y_done = 1'b0;
        u_if.z_done = 1'b0;
        if (u_if.start) begin
            case (mode)
                0: begin
                    u_if.x_done = (shcnt == 8'(d_lat - 1));
                    u_if.y_done = (shcnt == 8'(d_lat - 1));
                    u_if.z_done = (shcnt == 8'(d_lat - 1));
                end
                1: begin
                    u_if.x_done = (shcnt == 8'd4);
                    u_if.z_done = (shcnt == 8'd8);
                    u_if.y_done = (shcnt == 8'd11);
                end
                default: begin
                    u_if.x_done = (shcnt == 8'd2);
                    u_if.z_done = (shcnt == 8'd2);
                end
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_go();
        u_if.go = 1'b1;
        tick();
        u_if.go = 1'b0;
    endtask

    task automatic wait_start(input string tag);
        int n = 0;
        while (!u_if.start && n < 200) begin
            tick();
            n++;
        end
        check(tag, u_if.start, 1);
    endtask

    task automatic wait_low(input string tag);
        int n = 0;
        while (u_if.start && n < 200) begin
            tick();
            n++;
        end
        check(tag, u_if.start, 0);
    endtask

    // Abort via a clock-aligned reset pulse and return to a clean idle.
    task automatic reset_pulse();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    // Full run with mode 0 / d_lat=17; optional go pulse during iteration 5.
    // Returns with the sample taken in the FINISH cycle.
    task automatic run_full(input int go_iter5, input string tag);
        int   k = 1;
        int   done_k = 0;
        int   runs = 0;
        int   bad_len = 0;
        int   bad_iter = 0;
        int   rl = 0;
        int   maxit = 0;
        logic g5 = 1'b0;
        pulse_go();
        check({tag, "_load_iter"}, u_if.iter, 0);
        check({tag, "_load_busy"}, u_if.busy, 1);
        while (k < 1000) begin
            if (int'(u_if.iter) > maxit) maxit = int'(u_if.iter);
            if (u_if.start) begin
                if (rl == 0 && int'(u_if.iter) != runs + 1) bad_iter++;
                rl++;
            end else if (rl != 0) begin
                runs++;
                if (rl != 17) bad_len++;
                rl = 0;
            end
            if (u_if.done) begin
                done_k = k;
                break;
            end
            if (go_iter5 != 0 && !g5 && u_if.start && u_if.iter == 5'd5) begin
                u_if.go = 1'b1;
                g5 = 1'b1;
            end else begin
                u_if.go = 1'b0;
            end
            tick();
            k++;
        end
        u_if.go = 1'b0;
        check({tag, "_latency"},   done_k, 306);
        check({tag, "_passes"},    runs, 16);
        check({tag, "_pass_len"},  bad_len, 0);
        check({tag, "_iter_seq"},  bad_iter, 0);
        check({tag, "_max_iter"},  maxit, 16);
        check({tag, "_fin_iter"},  u_if.iter, 16);
        check({tag, "_fin_busy"},  u_if.busy, 0);
    endtask

    initial begin
        int n;
        rst         = 1'b1;
        u_if.go     = 1'b0;
        u_if.z_sign = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_outputs", {u_if.iter, u_if.start, u_if.op_x, u_if.op_y, u_if.op_z,
                              u_if.busy, u_if.done, u_if.err}, 0);
        rst = 1'b0;
        tick();
        check("idle_iter",  u_if.iter, 0);
        check("idle_start", u_if.start, 0);
        check("idle_busy",  u_if.busy, 0);

        // Nominal run, z_sign=0 throughout.
        mode  = 0;
        d_lat = 17;
        run_full(0, "nom");
        tick();
        check("nom_done_1cyc", u_if.done, 0);
        check("nom_held_iter", u_if.iter, 16);
        check("nom_ops_zpos",  {u_if.op_x, u_if.op_y, u_if.op_z}, 3'b101);

        // go during iteration 5 is ignored; go in FINISH is ignored; go in
        // the next IDLE cycle starts a new LOAD.
        run_full(1, "busygo");
        u_if.go = 1'b1;
        tick();
        check("fin_go_busy", u_if.busy, 0);
        check("fin_go_iter", u_if.iter, 16);
        check("fin_go_done", u_if.done, 0);
        tick();
        u_if.go = 1'b0;
        check("idle_go_busy", u_if.busy, 1);
        check("idle_go_iter", u_if.iter, 0);

        // Asynchronous reset in the middle of a SHIFT pass.
        wait_start("arst_reach_shift");
        rst = 1'b1;
        #1;
        check("arst_outputs", {u_if.iter, u_if.start, u_if.op_x, u_if.op_y, u_if.op_z,
                               u_if.busy, u_if.done, u_if.err}, 0);
        tick();
        rst = 1'b0;
        tick();
        check("arst_rel_iter",  u_if.iter, 0);
        check("arst_rel_start", u_if.start, 0);

        // Direction select and hold through SHIFT.
        d_lat       = 4;
        u_if.z_sign = 1'b1;
        pulse_go();
        wait_start("dir_neg_start");
        check("dir_neg_ops", {u_if.op_x, u_if.op_y, u_if.op_z}, 3'b010);
        u_if.z_sign = 1'b0;
        tick();
        check("dir_neg_hold", {u_if.op_x, u_if.op_y, u_if.op_z}, 3'b010);
        wait_low("dir_neg_end");
        wait_start("dir_pos_start");
        check("dir_pos_ops", {u_if.op_x, u_if.op_y, u_if.op_z}, 3'b101);
        u_if.z_sign = 1'b1;
        tick();
        check("dir_pos_hold", {u_if.op_x, u_if.op_y, u_if.op_z}, 3'b101);
        reset_pulse();

        // Staggered dones: pass ends after SHIFT cycle 12.
        mode = 1;
        pulse_go();
        wait_start("stag_start");
        n = 0;
        while (u_if.start && n < 100) begin
            n++;
            tick();
        end
        check("stag_len",        n, 12);
        check("stag_drop_iter",  u_if.iter, 1);
        check("stag_drop_busy",  u_if.busy, 1);
        tick();
        check("stag_arm_iter",   u_if.iter, 2);
        check("stag_arm_start",  u_if.start, 0);
        tick();
        check("stag_next_start", u_if.start, 1);
        reset_pulse();

        // Watchdog: y never answers.
        mode = 2;
        pulse_go();
        wait_start("wd_start");
        n = 0;
        while (u_if.start && n < 200) begin
            n++;
            tick();
        end
        check("wd_len",   n, 64);
        check("wd_err",   u_if.err, 1);
        check("wd_start_low", u_if.start, 0);
        check("wd_busy",  u_if.busy, 0);
        check("wd_iter",  u_if.iter, 1);
        tick();
        tick();
        check("wd_sticky", u_if.err, 1);
        mode = 0;
        pulse_go();
        check("wd_go_err",  u_if.err, 0);
        check("wd_go_busy", u_if.busy, 1);
        check("wd_go_iter", u_if.iter, 0);
        reset_pulse();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
